// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared constants, FSM state and reply-kind enums for cmd_parser
package cmd_pkg;

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam logic [7:0] OP_WR = 8'h57;
  localparam logic [7:0] OP_RD = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_DHI, S_DLO, S_CHK, S_EXEC, S_RDWAIT, S_RESP
  } state_e;

  typedef enum logic [1:0] {
    RSP_ACK, RSP_NAK, RSP_RD
  } rsp_e;

  function automatic logic [7:0] xor4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    return a ^ b ^ c ^ d;
  endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// rtl/cmd_parser_if.sv - RX/TX byte FIFO and register-bus signals of cmd_parser
interface cmd_parser_if;

  logic [7:0]                  rx_fifo_data;
  logic                        rx_fifo_empty;
  logic                        rx_fifo_rd_en;
  logic [7:0]                  tx_fifo_data;
  logic                        tx_fifo_wr_en;
  logic                        tx_fifo_full;
  logic [cmd_pkg::ADDR_W-1:0]  reg_addr;
  logic [cmd_pkg::DATA_W-1:0]  reg_wdata;
  logic                        reg_wr_en;
  logic                        reg_rd_en;
  logic [cmd_pkg::DATA_W-1:0]  reg_rdata;
  logic                        reg_rd_valid;
  logic [7:0]                  err_cnt;

  modport master (
    input  rx_fifo_data, rx_fifo_empty, tx_fifo_full, reg_rdata, reg_rd_valid,
    output rx_fifo_rd_en, tx_fifo_data, tx_fifo_wr_en, reg_addr, reg_wdata,
           reg_wr_en, reg_rd_en, err_cnt
  );

  modport slave (
    output rx_fifo_data, rx_fifo_empty, tx_fifo_full, reg_rdata, reg_rd_valid,
    input  rx_fifo_rd_en, tx_fifo_data, tx_fifo_wr_en, reg_addr, reg_wdata,
           reg_wr_en, reg_rd_en, err_cnt
  );

endinterface

// File: rtl/cmd_parser.sv
// rtl/cmd_parser.sv - host command frame decoder driving the register bus and reply FIFO
// CMD_CHECKSUM_EN adds a trailing XOR check byte to frames and to read replies.
module cmd_parser
  import cmd_pkg::*;
#(
  parameter int P_DATA_W      = DATA_W,
  parameter int P_ADDR_W      = ADDR_W,
  parameter int P_TIMEOUT_CYC = 500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  cmd_parser_if.master  bus
);

  localparam int TO_W = $clog2(P_TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(P_TIMEOUT_CYC - 1);
`ifdef CMD_CHECKSUM_EN
  localparam logic [2:0] RD_LAST = 3'd4;
`else
  localparam logic [2:0] RD_LAST = 3'd3;
`endif

  state_e              state_q, state_d;
  rsp_e                rsp_q, rsp_d;
  logic                inflight_q, inflight_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                bad_q, bad_d;
  logic                rd_q, rd_d;
  logic [P_ADDR_W-1:0] addr_q, addr_d;
  logic [P_DATA_W-1:0] data_q, data_d;
  logic [2:0]          idx_q, idx_d;
  logic [7:0]          err_q, err_d;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]          cmd_q, cmd_d;
`endif

  logic       rx_phase, armed, rd_en_c, reg_wr_c, reg_rd_c, tx_wr_c;
  logic [7:0] rx_byte, err_inc, rsp_byte, rsp_last;

  assign rx_byte  = bus.rx_fifo_data;
  assign rx_phase = (state_q == S_IDLE) || (state_q == S_CMD) || (state_q == S_ADDR) ||
                    (state_q == S_DHI)  || (state_q == S_DLO) || (state_q == S_CHK);
  assign armed    = rx_phase && (state_q != S_IDLE);
  assign err_inc  = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
  assign rsp_last = (rsp_q == RSP_RD) ? {5'd0, RD_LAST} : 8'd0;

  always_comb begin
    rsp_byte = 8'h00;
    case (rsp_q)
      RSP_ACK: rsp_byte = ACK;
      RSP_NAK: rsp_byte = NAK;
      default: begin
        case (idx_q)
          3'd0:    rsp_byte = SYNC;
          3'd1:    rsp_byte = addr_q;
          3'd2:    rsp_byte = data_q[15:8];
          3'd3:    rsp_byte = data_q[7:0];
          default: rsp_byte = xor4(8'h00, addr_q, data_q[15:8], data_q[7:0]);
        endcase
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rsp_d    = rsp_q;
    to_d     = '0;
    bad_d    = bad_q;
    rd_d     = rd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    idx_d    = idx_q;
    err_d    = err_q;
`ifdef CMD_CHECKSUM_EN
    cmd_d    = cmd_q;
`endif
    reg_wr_c = 1'b0;
    reg_rd_c = 1'b0;
    tx_wr_c  = 1'b0;
    // Only one pop outstanding: the popped byte is consumed the cycle after rd_en.
    rd_en_c    = rx_phase && !bus.rx_fifo_empty && !inflight_q;
    inflight_d = rd_en_c;

    case (state_q)
      S_IDLE: if (inflight_q && rx_byte == SYNC) begin
        state_d = S_CMD;
        bad_d   = 1'b0;
      end
      S_CMD: if (inflight_q) begin
        rd_d    = (rx_byte == OP_RD);
        bad_d   = (rx_byte != OP_RD) && (rx_byte != OP_WR);
`ifdef CMD_CHECKSUM_EN
        cmd_d   = rx_byte;
`endif
        state_d = S_ADDR;
      end
      S_ADDR: if (inflight_q) begin
        addr_d  = rx_byte;
        state_d = S_DHI;
      end
      S_DHI: if (inflight_q) begin
        data_d[15:8] = rx_byte;
        state_d      = S_DLO;
      end
      S_DLO: if (inflight_q) begin
        data_d[7:0] = rx_byte;
`ifdef CMD_CHECKSUM_EN
        state_d     = S_CHK;
`else
        state_d     = S_EXEC;
`endif
      end
`ifdef CMD_CHECKSUM_EN
      S_CHK: if (inflight_q) begin
        if (rx_byte != xor4(cmd_q, addr_q, data_q[15:8], data_q[7:0])) bad_d = 1'b1;
        state_d = S_EXEC;
      end
`endif
      S_EXEC: begin
        idx_d   = 3'd0;
        state_d = S_RESP;
        if (bad_q) begin
          rsp_d = RSP_NAK;
          err_d = err_inc;
        end else if (rd_q) begin
          reg_rd_c = 1'b1;
          rsp_d    = RSP_RD;
          state_d  = S_RDWAIT;
        end else begin
          reg_wr_c = 1'b1;
          rsp_d    = RSP_ACK;
        end
      end
      S_RDWAIT: if (bus.reg_rd_valid) begin
        data_d  = bus.reg_rdata;
        state_d = S_RESP;
      end
      S_RESP: if (!bus.tx_fifo_full) begin
        tx_wr_c = 1'b1;
        if ({5'd0, idx_q} == rsp_last) begin
          idx_d   = 3'd0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // An arriving byte always wins over an expiring inter-byte timer.
    if (armed && !inflight_q) begin
      if (to_q == TO_MAX) begin
        state_d = S_IDLE;
        err_d   = err_inc;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rsp_q      <= RSP_ACK;
      inflight_q <= 1'b0;
      to_q       <= '0;
      bad_q      <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      err_q      <= '0;
`ifdef CMD_CHECKSUM_EN
      cmd_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rsp_q      <= rsp_d;
      inflight_q <= inflight_d;
      to_q       <= to_d;
      bad_q      <= bad_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
`ifdef CMD_CHECKSUM_EN
      cmd_q      <= cmd_d;
`endif
    end
  end

  assign bus.rx_fifo_rd_en = rd_en_c;
  assign bus.tx_fifo_wr_en = tx_wr_c;
  assign bus.tx_fifo_data  = (state_q == S_RESP) ? rsp_byte : 8'h00;
  assign bus.reg_addr      = addr_q;
  assign bus.reg_wdata     = data_q;
  assign bus.reg_wr_en     = reg_wr_c;
  assign bus.reg_rd_en     = reg_rd_c;
  assign bus.err_cnt       = err_q;

endmodule

// File: tb/tb_cmd_parser.sv
// tb/tb_cmd_parser.sv - self-checking bench for cmd_parser (table vectors plus corner sequences)
module tb_cmd_parser;
  import cmd_pkg::*;

  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_parser_if ifc();
  cmd_parser #(.P_TIMEOUT_CYC(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int checks = 0;
  int errors = 0;

  // RX FIFO model: normal-mode read, data valid the cycle after rd_en.
  logic [7:0] rx_mem [0:4095];
  int rx_wp = 0;
  int rx_rp = 0;
  assign ifc.rx_fifo_empty = (rx_wp == rx_rp);
  always @(posedge clk) begin
    if (ifc.rx_fifo_rd_en && rx_wp != rx_rp) begin
      ifc.rx_fifo_data <= rx_mem[rx_rp % 4096];
      rx_rp <= rx_rp + 1;
    end
  end

  logic tx_full = 1'b0;
  assign ifc.tx_fifo_full = tx_full;
  logic [7:0] tx_mem [0:4095];
  int tx_n = 0;
  int full_push = 0;
  always @(posedge clk) begin
    if (ifc.tx_fifo_wr_en) begin
      tx_mem[tx_n % 4096] <= ifc.tx_fifo_data;
      tx_n <= tx_n + 1;
      if (ifc.tx_fifo_full) full_push <= full_push + 1;
    end
  end

  // Register slave: read data returns 3 cycles after the read strobe.
  int wr_n = 0;
  int rd_n = 0;
  int dly = 0;
  logic [7:0]  wr_addr = 8'h00;
  logic [7:0]  rd_addr = 8'h00;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] rd_value = 16'h0000;
  always @(posedge clk) begin
    if (ifc.reg_wr_en) begin
      wr_n <= wr_n + 1;
      wr_addr <= ifc.reg_addr;
      wr_data <= ifc.reg_wdata;
    end
    if (ifc.reg_rd_en) begin
      rd_n <= rd_n + 1;
      rd_addr <= ifc.reg_addr;
      dly <= 3;
    end else if (dly > 0) begin
      dly <= dly - 1;
    end
  end
  assign ifc.reg_rd_valid = (dly == 1);
  assign ifc.reg_rdata    = (dly == 1) ? rd_value : 16'hDEAD;

  typedef struct {
    logic [15:0] pre;
    int          npre;
    logic [7:0]  cmd, addr, hi, lo;
    logic [15:0] rdv;
    int          ewr, erd;
    logic [7:0]  eaddr;
    logic [15:0] ewd;
    logic [39:0] etx;
    int          etxn;
    logic [7:0]  eerr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    rx_mem[rx_wp % 4096] = b;
    rx_wp = rx_wp + 1;
  endtask

  task automatic push_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] h, input logic [7:0] l);
    push(SYNC); push(c); push(a); push(h); push(l);
`ifdef CMD_CHECKSUM_EN
    push(c ^ a ^ h ^ l);
`endif
  endtask

  task automatic wait_tx(input int n, input int bound, input string name);
    int k = 0;
    while (tx_n < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (tx_n < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout tx_count=%0d required=%0d", name, tx_n, n);
    end
  endtask

  initial begin
    int t0, w0, r0;
    logic [7:0] e0;

    vecs[0] = '{pre:16'h0, npre:0, cmd:8'h57, addr:8'h10, hi:8'h12, lo:8'h34, rdv:16'h0,
                ewr:1, erd:0, eaddr:8'h10, ewd:16'h1234, etx:40'h0600000000, etxn:1, eerr:8'd0};
    vecs[1] = '{pre:16'h0, npre:0, cmd:8'h52, addr:8'h10, hi:8'h00, lo:8'h00, rdv:16'hBEEF,
                ewr:0, erd:1, eaddr:8'h10, ewd:16'h0, etx:40'hA510BEEF00, etxn:4, eerr:8'd0};
    vecs[2] = '{pre:16'h00FF, npre:2, cmd:8'h57, addr:8'h01, hi:8'h00, lo:8'h05, rdv:16'h0,
                ewr:1, erd:0, eaddr:8'h01, ewd:16'h0005, etx:40'h0600000000, etxn:1, eerr:8'd0};
    vecs[3] = '{pre:16'h0, npre:0, cmd:8'h58, addr:8'h01, hi:8'h02, lo:8'h03, rdv:16'h0,
                ewr:0, erd:0, eaddr:8'h0, ewd:16'h0, etx:40'h1500000000, etxn:1, eerr:8'd1};
    vecs[4] = '{pre:16'h0, npre:0, cmd:8'h52, addr:8'h7F, hi:8'h99, lo:8'h88, rdv:16'h1234,
                ewr:0, erd:1, eaddr:8'h7F, ewd:16'h0, etx:40'hA57F123400, etxn:4, eerr:8'd1};
    vecs[5] = '{pre:16'h0, npre:0, cmd:8'h57, addr:8'hFF, hi:8'hFF, lo:8'hFF, rdv:16'h0,
                ewr:1, erd:0, eaddr:8'hFF, ewd:16'hFFFF, etx:40'h0600000000, etxn:1, eerr:8'd1};
    vecs[6] = '{pre:16'h0, npre:0, cmd:8'h00, addr:8'h20, hi:8'h00, lo:8'h01, rdv:16'h0,
                ewr:0, erd:0, eaddr:8'h0, ewd:16'h0, etx:40'h1500000000, etxn:1, eerr:8'd2};
`ifdef CMD_CHECKSUM_EN
    vecs[1].etx[7:0] = 8'h41; vecs[1].etxn = 5;
    vecs[4].etx[7:0] = 8'h59; vecs[4].etxn = 5;
`endif

    repeat (3) @(negedge clk);
    chk("rst_rx_rd_en", ifc.rx_fifo_rd_en, 1'b0);
    chk("rst_tx_wr_en", ifc.tx_fifo_wr_en, 1'b0);
    chk("rst_tx_data", ifc.tx_fifo_data, 8'h00);
    chk("rst_reg_wr_en", ifc.reg_wr_en, 1'b0);
    chk("rst_reg_rd_en", ifc.reg_rd_en, 1'b0);
    chk("rst_reg_addr", ifc.reg_addr, 8'h00);
    chk("rst_reg_wdata", ifc.reg_wdata, 16'h0000);
    chk("rst_err_cnt", ifc.err_cnt, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      rd_value = vecs[i].rdv;
      t0 = tx_n; w0 = wr_n; r0 = rd_n;
      for (int j = 0; j < vecs[i].npre; j++) push(vecs[i].pre[15-8*j -: 8]);
      push_frame(vecs[i].cmd, vecs[i].addr, vecs[i].hi, vecs[i].lo);
      wait_tx(t0 + vecs[i].etxn, 500, $sformatf("v%0d_tx", i));
      repeat (6) @(negedge clk);
      chk($sformatf("v%0d_tx_count", i), tx_n - t0, vecs[i].etxn);
      chk($sformatf("v%0d_wr_count", i), wr_n - w0, vecs[i].ewr);
      chk($sformatf("v%0d_rd_count", i), rd_n - r0, vecs[i].erd);
      if (vecs[i].ewr != 0) begin
        chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].eaddr);
        chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].ewd);
      end
      if (vecs[i].erd != 0) chk($sformatf("v%0d_rd_addr", i), rd_addr, vecs[i].eaddr);
      for (int j = 0; j < vecs[i].etxn; j++)
        chk($sformatf("v%0d_tx_byte%0d", i, j), tx_mem[(t0 + j) % 4096], vecs[i].etx[39-8*j -: 8]);
      chk($sformatf("v%0d_err_cnt", i), ifc.err_cnt, vecs[i].eerr);
    end

`ifdef CMD_CHECKSUM_EN
    t0 = tx_n; w0 = wr_n; e0 = ifc.err_cnt;
    push(SYNC); push(8'h57); push(8'h03); push(8'h00); push(8'h01); push(8'h00);
    wait_tx(t0 + 1, 500, "badchk_tx");
    repeat (4) @(negedge clk);
    chk("badchk_reply", tx_mem[t0 % 4096], NAK);
    chk("badchk_no_write", wr_n - w0, 0);
    chk("badchk_err_cnt", ifc.err_cnt, e0 + 8'd1);
`endif

    // Inter-byte timeout aborts a partial frame silently, then a good frame follows.
    t0 = tx_n; w0 = wr_n; e0 = ifc.err_cnt;
    push(SYNC); push(OP_WR);
    repeat (TO + 40) @(negedge clk);
    chk("to_no_reply", tx_n - t0, 0);
    chk("to_err_cnt", ifc.err_cnt, e0 + 8'd1);
    push_frame(8'h57, 8'h02, 8'h00, 8'h07);
    wait_tx(t0 + 1, 500, "to_next_tx");
    repeat (4) @(negedge clk);
    chk("to_next_wr_count", wr_n - w0, 1);
    chk("to_next_wr_addr", wr_addr, 8'h02);
    chk("to_next_wr_data", wr_data, 16'h0007);
    chk("to_next_reply", tx_mem[t0 % 4096], ACK);

    // TX FIFO full held mid-reply: no push while full, reply order preserved.
    t0 = tx_n;
    rd_value = 16'hCAFE;
    push_frame(8'h52, 8'h33, 8'h00, 8'h00);
    wait_tx(t0 + 1, 500, "full_first");
    tx_full = 1'b1;
    repeat (50) @(negedge clk);
    chk("full_hold_count", tx_n - t0, 1);
    tx_full = 1'b0;
`ifdef CMD_CHECKSUM_EN
    wait_tx(t0 + 5, 500, "full_rest");
    chk("full_byte4", tx_mem[(t0 + 4) % 4096], 8'h07);
`else
    wait_tx(t0 + 4, 500, "full_rest");
`endif
    chk("full_byte0", tx_mem[t0 % 4096], 8'hA5);
    chk("full_byte1", tx_mem[(t0 + 1) % 4096], 8'h33);
    chk("full_byte2", tx_mem[(t0 + 2) % 4096], 8'hCA);
    chk("full_byte3", tx_mem[(t0 + 3) % 4096], 8'hFE);
    chk("full_push_while_full", full_push, 0);

    // Async reset mid-frame drops the partial frame.
    repeat (4) @(negedge clk);
    push(SYNC); push(OP_WR); push(8'h10);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_err_cnt", ifc.err_cnt, 8'h00);
    chk("midrst_reg_addr", ifc.reg_addr, 8'h00);
    chk("midrst_rx_rd_en", ifc.rx_fifo_rd_en, 1'b0);
    chk("midrst_tx_wr_en", ifc.tx_fifo_wr_en, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    t0 = tx_n; w0 = wr_n;
    push_frame(8'h57, 8'h44, 8'h01, 8'h02);
    wait_tx(t0 + 1, 500, "midrst_tx");
    repeat (4) @(negedge clk);
    chk("midrst_wr_count", wr_n - w0, 1);
    chk("midrst_wr_data", wr_data, 16'h0102);
    chk("midrst_reply", tx_mem[t0 % 4096], ACK);
    chk("midrst_err_after", ifc.err_cnt, 8'h00);

    // err_cnt saturation: 254 rejects -> FE, two more -> FF.
    t0 = tx_n; w0 = wr_n;
    for (int i = 0; i < 254; i++) push_frame(8'h58, 8'h01, 8'h02, 8'h03);
    wait_tx(t0 + 254, 8000, "sat_a");
    repeat (4) @(negedge clk);
    chk("sat_err_fe", ifc.err_cnt, 8'hFE);
    for (int i = 0; i < 2; i++) push_frame(8'h58, 8'h01, 8'h02, 8'h03);
    wait_tx(t0 + 256, 500, "sat_b");
    repeat (4) @(negedge clk);
    chk("sat_err_ff", ifc.err_cnt, 8'hFF);
    chk("sat_last_reply", tx_mem[(t0 + 255) % 4096], NAK);
    chk("sat_no_write", wr_n - w0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
